// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl
//
// Turns a roll request (die type, dice count) into a dice sum. It draws
// decimal digits from the dice random generator and uses rejection sampling
// so that each face is equally likely. The result is registered, with a
// one-cycle valid pulse.
//
// d4/d6/d8/d10 use one digit per attempt. d12/d20/d100 use two digits per
// attempt (hi then lo), forming v = hi*10 + lo. An attempt is accepted when
// every digit is <= 9 and v is below the die's limit. The attempt that
// reaches MAX_TRIES is accepted anyway, and the roll is flagged as biased.
// Each accepted die advances tap_sel (0..6) to stir the generator.
//
// Parameters:
//   SAMPLE_GAP  idle cycles before every digit sample (0..15)
//   MAX_TRIES   attempts per die before forced acceptance (1..255)
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   roll_req      start a roll (sampled only when idle)
//   die_sel       0:d4 1:d6 2:d8 3:d10 4:d12 5:d20 6:d100 7:d10
//   num_dice      dice per roll, 0 treated as 1
//   rnd_in        random digit from generator (nominally 0..9)
//   tap_sel       tap-select to generator
//   busy          roll in progress
//   result        dice sum of the last completed roll
//   result_valid  one-cycle pulse when result updates
//   biased        last roll contained at least one force-accepted die
module dice_roll_ctrl #(
  parameter int unsigned SAMPLE_GAP = 1,
  parameter int unsigned MAX_TRIES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [2:0] die_sel,
  input  logic [2:0] num_dice,
  input  logic [3:0] rnd_in,
  output logic [2:0] tap_sel,
  output logic       busy,
  output logic [9:0] result,
  output logic       result_valid,
  output logic       biased
);

  localparam bit         GapEn   = (SAMPLE_GAP != 0);
  localparam logic [3:0] GapLast = 4'((SAMPLE_GAP == 0) ? 0 : SAMPLE_GAP - 1);
  localparam logic [7:0] TryLast = 8'((MAX_TRIES == 0) ? 0 : MAX_TRIES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StDigHi,
    StDigLo,
    StDone
  } state_e;

  state_e     state_q;
  logic [2:0] die_q;
  logic [2:0] dice_left_q;
  logic [3:0] gap_cnt_q;
  logic [3:0] hi_q;
  logic       hi_bad_q;
  logic       lo_phase_q;    // the pending gap leads into DIG_LO, not DIG_HI
  logic [7:0] try_cnt_q;     // rejected attempts on the current die
  logic [9:0] sum_q;

  // Die decode
  logic       two_digit;
  logic [7:0] modulus;
  logic [7:0] limit;

  always_comb begin
    two_digit = 1'b0;
    modulus   = 8'd10;
    limit     = 8'd10;
    unique case (die_q)
      3'd0: begin
        modulus = 8'd4;
        limit   = 8'd8;
      end
      3'd1: begin
        modulus = 8'd6;
        limit   = 8'd6;
      end
      3'd2: begin
        modulus = 8'd8;
        limit   = 8'd8;
      end
      3'd4: begin
        two_digit = 1'b1;
        modulus   = 8'd12;
        limit     = 8'd96;
      end
      3'd5: begin
        two_digit = 1'b1;
        modulus   = 8'd20;
        limit     = 8'd100;
      end
      3'd6: begin
        two_digit = 1'b1;
        modulus   = 8'd100;
        limit     = 8'd100;
      end
      default: begin
        // d10 (codes 3 and 7)
        two_digit = 1'b0;
        modulus   = 8'd10;
        limit     = 8'd10;
      end
    endcase
  end

  // Attempt evaluation. It is only meaningful in a deciding digit state.
  logic [7:0] value;
  logic [7:0] value_mod;
  logic [7:0] face;
  logic       digit_bad;
  logic       in_range;
  logic       force_acc;
  logic       accept;

  always_comb begin
    if (state_q == StDigLo) begin
      value     = ({4'd0, hi_q} * 8'd10) + {4'd0, rnd_in};
      digit_bad = hi_bad_q | (rnd_in > 4'd9);
    end else begin
      value     = {4'd0, rnd_in};
      digit_bad = (rnd_in > 4'd9);
    end
    in_range  = !digit_bad && (value < limit);
    force_acc = (try_cnt_q >= TryLast);
    accept    = in_range | force_acc;
    value_mod = value % modulus;
    face      = value_mod + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      die_q        <= '0;
      dice_left_q  <= '0;
      gap_cnt_q    <= '0;
      hi_q         <= '0;
      hi_bad_q     <= 1'b0;
      lo_phase_q   <= 1'b0;
      try_cnt_q    <= '0;
      sum_q        <= '0;
      tap_sel      <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      biased       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (roll_req) begin
            die_q       <= die_sel;
            dice_left_q <= (num_dice == 3'd0) ? 3'd1 : num_dice;
            sum_q       <= '0;
            try_cnt_q   <= '0;
            biased      <= 1'b0;
            busy        <= 1'b1;
            lo_phase_q  <= 1'b0;
            gap_cnt_q   <= '0;
            state_q     <= GapEn ? StGap : StDigHi;
          end
        end

        StGap: begin
          if (gap_cnt_q == GapLast) begin
            gap_cnt_q <= '0;
            state_q   <= lo_phase_q ? StDigLo : StDigHi;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end

        StDigHi, StDigLo: begin
          gap_cnt_q <= '0;
          if ((state_q == StDigHi) && two_digit) begin
            // First digit of a two-digit attempt. The decision waits for lo.
            hi_q       <= rnd_in;
            hi_bad_q   <= (rnd_in > 4'd9);
            lo_phase_q <= 1'b1;
            state_q    <= GapEn ? StGap : StDigLo;
          end else begin
            lo_phase_q <= 1'b0;
            state_q    <= GapEn ? StGap : StDigHi;
            if (accept) begin
              sum_q     <= sum_q + {2'b00, face};
              tap_sel   <= (tap_sel == 3'd6) ? 3'd0 : tap_sel + 3'd1;
              try_cnt_q <= '0;
              if (!in_range) begin
                biased <= 1'b1;
              end
              if (dice_left_q == 3'd1) begin
                state_q <= StDone;
              end else begin
                dice_left_q <= dice_left_q - 3'd1;
              end
            end else begin
              try_cnt_q <= try_cnt_q + 8'd1;
            end
          end
        end

        StDone: begin
          result       <= sum_q;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state_q      <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
